// File: rtl/cgate_pkg.sv
// Shared types and helpers for the A&(B|C) complex-gate stimulus/check stage.
// Holds the FSM encoding, vector bit positions and the expected-value function.
package cgate_pkg;

    localparam int SETTLE_DEF = 2;

    // Vector index bit that drives each cell input; A toggles fastest.
    localparam int BIT_A = 0;
    localparam int BIT_C = 1;
    localparam int BIT_B = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } cgate_state_e;

    function automatic logic exp_abc(input logic [2:0] idx);
        return idx[BIT_A] & (idx[BIT_B] | idx[BIT_C]);
    endfunction

endpackage

// File: rtl/cgate_dwell_timer.sv
// Dwell timer: clamps the requested dwell to SETTLE+1, latches it at load and
// down-counts each held vector, strobing last_cycle on the final hold cycle.
module cgate_dwell_timer
    import cgate_pkg::*;
#(
    parameter int DWELL_W = 8,
    parameter int SETTLE  = SETTLE_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               run,
    input  logic [DWELL_W-1:0] dwell,
    output logic               last_cycle
);

    localparam logic [DWELL_W-1:0] MIN_D = DWELL_W'(SETTLE + 1);

    logic [DWELL_W-1:0] dwell_eff;
    logic [DWELL_W-1:0] d_lat;
    logic [DWELL_W-1:0] cnt;

    assign dwell_eff  = (dwell < MIN_D) ? MIN_D : dwell;
    assign last_cycle = run && (cnt == '0);

    // Counter holds "cycles remaining after this one"; it reloads on the last cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_lat <= '0;
            cnt   <= '0;
        end else if (load) begin
            d_lat <= dwell_eff;
            cnt   <= dwell_eff - 1'b1;
        end else if (run) begin
            if (cnt == '0) begin
                cnt <= d_lat - 1'b1;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/cgate_stim_checker.sv
// Sweeps A/B/C through all 8 vectors with a programmable dwell, samples both
// cell outputs on the last dwell cycle and accumulates pass/err_cnt/err_mask.
module cgate_stim_checker
    import cgate_pkg::*;
#(
    parameter int DWELL_W = 8,
    parameter int SETTLE  = SETTLE_DEF,
    parameter int ERR_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               abc_1,
    input  logic               abc_2,
    output logic               A,
    output logic               C,
    output logic               B,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_cnt,
    output logic [7:0]         err_mask,
    output logic [2:0]         vec_idx,
    output cgate_state_e       dbg_state
);

    // Handshake: a sweep is accepted when start=1 and abort=0 while IDLE (busy=0);
    // busy stays high through DONE and done pulses for exactly one cycle.

    cgate_state_e state_q, state_d;
    logic         go;
    logic         run;
    logic         sample;
    logic         exp_v;
    logic         mismatch;
    logic [ERR_W-1:0] err_cnt_nxt;
    logic [2:0]   stim;

    assign go  = (state_q == IDLE) && start && !abort;
    assign run = (state_q == HOLD) && !abort;

    cgate_dwell_timer #(
        .DWELL_W (DWELL_W),
        .SETTLE  (SETTLE)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (go),
        .run        (run),
        .dwell      (dwell),
        .last_cycle (sample)
    );

    assign exp_v    = exp_abc(vec_idx);
    assign mismatch = (abc_1 != exp_v) || (abc_2 != exp_v);

    always_comb begin
        err_cnt_nxt = err_cnt;
        if (sample && mismatch && (err_cnt != {ERR_W{1'b1}})) begin
            err_cnt_nxt = err_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (go) state_d = HOLD;
            HOLD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (sample && (vec_idx == 3'd7)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
        stim      = (state_q == HOLD) ? vec_idx : 3'd0;
        A         = stim[BIT_A];
        C         = stim[BIT_C];
        B         = stim[BIT_B];
        dbg_state = state_q;
    end

    // pass is resolved on the final sample so it is already valid in the DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_idx  <= '0;
            err_cnt  <= '0;
            err_mask <= '0;
            pass     <= 1'b0;
        end else if (go) begin
            vec_idx  <= '0;
            err_cnt  <= '0;
            err_mask <= '0;
            pass     <= 1'b0;
        end else if (sample) begin
            err_cnt <= err_cnt_nxt;
            if (mismatch) begin
                err_mask[vec_idx] <= 1'b1;
            end
            if (vec_idx != 3'd7) begin
                vec_idx <= vec_idx + 1'b1;
            end else begin
                pass <= (err_cnt_nxt == '0);
            end
        end
    end

endmodule

// File: tb/tb_cgate_stim_checker.sv
// Directed bench for cgate_stim_checker: full sweeps with ideal and faulty cell
// models, dwell clamping, abort mid-sweep and asynchronous reset mid-hold.
module tb_cgate_stim_checker;
    import cgate_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         abort;
    logic [7:0]   dwell;
    logic         abc_1;
    logic         abc_2;
    logic         A, B, C;
    logic         busy, done, pass;
    logic [3:0]   err_cnt;
    logic [7:0]   err_mask;
    logic [2:0]   vec_idx;
    cgate_state_e dbg_state;

    int total;
    int bad;
    int mode;   // 0 ideal, 1 abc_2 stuck at 0, 2 abc_1 stuck at 1

    cgate_stim_checker dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .dwell     (dwell),
        .abc_1     (abc_1),
        .abc_2     (abc_2),
        .A         (A),
        .C         (C),
        .B         (B),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_cnt   (err_cnt),
        .err_mask  (err_mask),
        .vec_idx   (vec_idx),
        .dbg_state (dbg_state)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cell model with injectable faults
    always_comb begin
        abc_1 = A & (B | C);
        abc_2 = A & (B | C);
        if (mode == 2) abc_1 = 1'b1;
        if (mode == 1) abc_2 = 1'b0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Drives start so that the next rising edge (edge t) accepts it.
    task automatic begin_sweep(input logic [7:0] d);
        @(negedge clk);
        dwell = d;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_sweep(input logic [7:0] d, input int d_eff, input logic [7:0] exp_mask,
                             input logic [3:0] exp_cnt, input logic exp_pass, input bit poke_start);
        logic [2:0] j;
        begin_sweep(d);
        for (int k = 1; k <= 8 * d_eff + 1; k++) begin
            @(negedge clk);
            if (poke_start) start = (k == 10);
            if (k <= 8 * d_eff && ((k - 1) % d_eff) == 0) begin
                j = 3'((k - 1) / d_eff);
                chk("vec_idx", 32'(vec_idx), 32'(j));
                chk("abc_drive", {29'd0, B, C, A}, {29'd0, j[2], j[1], j[0]});
            end
            if (k == 8 * d_eff) chk("done_early", 32'(done), 32'd0);
            if (k == 8 * d_eff + 1) begin
                chk("done_pulse", 32'(done), 32'd1);
                chk("busy_in_done", 32'(busy), 32'd1);
                chk("pass", 32'(pass), 32'(exp_pass));
                chk("err_cnt", 32'(err_cnt), 32'(exp_cnt));
                chk("err_mask", 32'(err_mask), 32'(exp_mask));
            end
        end
        start = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_abc", {29'd0, B, C, A}, 32'd0);
        chk("hold_mask", 32'(err_mask), 32'(exp_mask));
        chk("hold_pass", 32'(pass), 32'(exp_pass));
    endtask

    initial begin
        bit seen_done;
        total = 0;
        bad   = 0;
        mode  = 0;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        dwell = 8'd4;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_abc", {29'd0, B, C, A}, 32'd0);
        chk("rst_vec", 32'(vec_idx), 32'd0);
        chk("rst_err", {20'd0, err_cnt, err_mask}, 32'd0);
        chk("rst_pass_done", {30'd0, pass, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: ideal cell, dwell 4, plus a start pulse while busy (ignored)
        run_sweep(8'd4, 4, 8'h00, 4'd0, 1'b1, 1'b1);
        // 2: abc_2 stuck at 0
        mode = 1;
        run_sweep(8'd4, 4, 8'hA8, 4'd3, 1'b0, 1'b0);
        // 3: abc_1 stuck at 1
        mode = 2;
        run_sweep(8'd4, 4, 8'h57, 4'd5, 1'b0, 1'b0);
        // 4: dwell 0 clamps to 3
        mode = 0;
        run_sweep(8'd0, 3, 8'h00, 4'd0, 1'b1, 1'b0);

        // 5: abort while vector 4 is driven
        mode = 1;
        begin_sweep(8'd4);
        for (int k = 1; k <= 17; k++) @(negedge clk);
        chk("abort_vec4", 32'(vec_idx), 32'd4);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_abc", {29'd0, B, C, A}, 32'd0);
        chk("abort_partial", {20'd0, err_cnt, err_mask}, {20'd0, 4'd1, 8'h08});
        chk("abort_pass", 32'(pass), 32'd0);
        seen_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        chk("abort_no_done", 32'(seen_done), 32'd0);
        // start together with abort in IDLE stays idle
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle", 32'(busy), 32'd0);
        mode = 0;
        run_sweep(8'd4, 4, 8'h00, 4'd0, 1'b1, 1'b0);

        // 6: asynchronous reset between edges mid-hold
        mode = 1;
        begin_sweep(8'd4);
        for (int k = 1; k <= 20; k++) @(negedge clk);
        chk("pre_rst_state", {22'd0, busy, B, err_mask}, {22'd0, 1'b1, 1'b1, 8'h08});
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_abc", {29'd0, B, C, A}, 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_mask", 32'(err_mask), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mode = 0;
        run_sweep(8'd5, 5, 8'h00, 4'd0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
